// File: rtl/line_window_buffer.sv
// Line window buffer: turns a raster pixel stream into vertical KERNEL_H-pixel columns with x/y, border and frame-end tags.
// Latency: one cycle from an accepted pixel to its column in the output register; one pixel per cycle sustained.
// Backpressure: in_ready drops combinationally while a held column is not taken, so counters and line memories freeze.
module line_window_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int KERNEL_H   = 3,
    parameter int KERNEL_W   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [KERNEL_H*DATA_WIDTH-1:0]     out_column,
    output logic [$clog2(IMG_WIDTH)-1:0]       out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]      out_y,
    output logic                               border_flag,
    output logic                               frame_last,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int NL = KERNEL_H - 1;

    // Typed constants keep every compare at the counter's own width.
    localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_PRIMED   = YW'(KERNEL_H - 1);
    localparam logic [XW-1:0] X_BORDER   = XW'(KERNEL_W - 1);

    // Raster position of the pixel currently offered at the input.
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic acc;
    logic x_last;
    logic y_last;
    logic primed;

    // Column read out of the line memories at x, before this cycle's write.
    logic [DATA_WIDTH-1:0] mem_rd [NL];
    // Data each line memory takes at x on an accepted pixel (shift-down).
    logic [DATA_WIDTH-1:0] mem_wr [NL];

    logic [KERNEL_H*DATA_WIDTH-1:0] col_next;

    // A new pixel can enter whenever the output register is empty or being drained.
    always_comb begin
        in_ready = !out_valid || out_ready;
        acc      = in_valid && in_ready;
        x_last   = (x == X_LAST);
        y_last   = (y == Y_LAST);
        primed   = (y >= Y_PRIMED);
    end

    // Line memories: no reset, asynchronous read, one write per accepted pixel.
    // Rows before KERNEL_H-1 never produce output, so stale contents from an
    // earlier frame (or power-up) can never reach out_column.
    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

        assign mem_rd[k] = mem[x];

        // Store this line's shifted-down pixel at the current column.
        always_ff @(posedge clk) begin
            if (acc) begin
                mem[x] <= mem_wr[k];
            end
        end
    end

    // Line 0 takes the incoming pixel; each deeper line takes the one above it.
    always_comb begin
        mem_wr[0] = in_data;
        for (int k = 1; k < NL; k++) begin
            mem_wr[k] = mem_rd[k-1];
        end
    end

    // Assemble the column: slice 0 is the live pixel, slice i is i rows up.
    always_comb begin
        col_next                  = '0;
        col_next[DATA_WIDTH-1:0]  = in_data;
        for (int i = 1; i < KERNEL_H; i++) begin
            col_next[DATA_WIDTH*i +: DATA_WIDTH] = mem_rd[i-1];
        end
    end

    // Raster counters advance only on accepted pixels, wrapping at line and frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (acc) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Output payload loads on every accept and is otherwise held for the sink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_column  <= '0;
            out_x       <= '0;
            out_y       <= '0;
            border_flag <= 1'b0;
            frame_last  <= 1'b0;
        end else if (acc) begin
            out_column  <= col_next;
            out_x       <= x;
            out_y       <= y;
            border_flag <= (x < X_BORDER);
            frame_last  <= x_last && y_last;
        end
    end

    // Valid flag: set by a primed accept, cleared when the sink takes the column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (acc) begin
            out_valid <= primed;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int KH = 3;
    localparam int KW = 3;
    localparam int FRAME = W * H;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [KH*DW-1:0]  out_column;
    logic [1:0]        out_x;
    logic [1:0]        out_y;
    logic              border_flag;
    logic              frame_last;
    logic              out_valid;
    logic              out_ready;

    line_window_buffer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .KERNEL_H   (KH),
        .KERNEL_W   (KW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_column  (out_column),
        .out_x       (out_x),
        .out_y       (out_y),
        .border_flag (border_flag),
        .frame_last  (frame_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [KH*DW-1:0] col;
        logic [1:0]       x;
        logic [1:0]       y;
        logic             border;
        logic             last;
    } exp_t;

    logic [DW-1:0] hist[$];   // every pixel accepted since the last reset, in order
    exp_t          expq[$];   // columns the sink still has to receive

    // Position comes from the accept count; the column is the pixels W, 2W.. accepts back.
    task automatic model_accept(input logic [DW-1:0] d);
        int   n, pos, ex, ey;
        exp_t e;
        hist.push_back(d);
        n   = hist.size() - 1;
        pos = n % FRAME;
        ex  = pos % W;
        ey  = pos / W;
        if (ey >= KH - 1) begin
            e.col = '0;
            for (int i = 0; i < KH; i++) begin
                e.col[DW*i +: DW] = hist[n - i*W];
            end
            e.x      = 2'(ex);
            e.y      = 2'(ey);
            e.border = (ex < KW - 1);
            e.last   = (ex == W - 1) && (ey == H - 1);
            expq.push_back(e);
        end
    endtask

    // ---------------- compare process ----------------
    logic             held;
    logic [KH*DW-1:0] snap_col;
    logic [1:0]       snap_x, snap_y;
    logic             snap_b, snap_l;

    initial held = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_column", out_column, 0);
            chk("rst_out_x", out_x, 0);
            chk("rst_out_y", out_y, 0);
            chk("rst_border", border_flag, 0);
            chk("rst_frame_last", frame_last, 0);
            chk("rst_in_ready", in_ready, 1);
            hist.delete();
            expq.delete();
            held = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_column", out_column, snap_col);
                chk("hold_x", out_x, snap_x);
                chk("hold_y", out_y, snap_y);
                chk("hold_border", border_flag, snap_b);
                chk("hold_last", frame_last, snap_l);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: out_valid with no pending column at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("col", out_column, e.col);
                    chk("x", out_x, e.x);
                    chk("y", out_y, e.y);
                    chk("border", border_flag, e.border);
                    chk("last", frame_last, e.last);
                end
            end
            if (in_valid && in_ready) model_accept(in_data);
            held     = out_valid && !out_ready;
            snap_col = out_column;
            snap_x   = out_x;
            snap_y   = out_y;
            snap_b   = border_flag;
            snap_l   = frame_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer one pixel; returns just after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d);
        int   n;
        logic ok;
        in_valid = 1'b1;
        in_data  = d;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 64);
        if (!ok) chk("send_timeout", {31'b0, ok}, 1);
        in_valid = 1'b0;
    endtask

    // Send one priming pixel and confirm it produced nothing.
    task automatic send_prime(input logic [DW-1:0] d);
        send(d);
        @(negedge clk);
        chk("prime_no_valid", out_valid, 0);
        chk("prime_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] rnd[48];
    int            idx;
    int            cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Frame 0: pixel = 4*y + x.
        for (int p = 0; p < 8; p++) send_prime(DW'(p));

        send(8'd8);
        @(negedge clk);
        chk("first_valid", out_valid, 1);
        chk("first_col", out_column, 24'h000408);
        chk("first_x", out_x, 0);
        chk("first_y", out_y, 2);
        chk("first_border", border_flag, 1);
        @(posedge clk);
        #1;

        send(8'd9);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd10;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_col", out_column, 24'h010509);
            chk("bp_x", out_x, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'd10);
        @(negedge clk);
        chk("px10_col", out_column, 24'h02060A);
        chk("px10_border", border_flag, 0);
        chk("px10_x", out_x, 2);
        @(posedge clk);
        #1;

        for (int p = 11; p < 15; p++) send(DW'(p));
        @(negedge clk);
        chk("px14_last", frame_last, 0);
        @(posedge clk);
        #1;
        send(8'd15);
        @(negedge clk);
        chk("px15_last", frame_last, 1);
        chk("px15_col", out_column, 24'h070B0F);
        chk("px15_y", out_y, 3);
        @(posedge clk);
        #1;

        // Frame 1: pixel = 16 + 4*y + x; must not see frame-0 rows.
        for (int p = 0; p < 8; p++) send_prime(DW'(16 + p));
        send(8'd24);
        @(negedge clk);
        chk("f1_valid", out_valid, 1);
        chk("f1_col", out_column, 24'h101418);
        chk("f1_y", out_y, 2);
        @(posedge clk);
        #1;
        for (int p = 9; p < 16; p++) send(DW'(16 + p));

        // Three frames of random data with random source and sink bubbles.
        for (int i = 0; i < 48; i++) rnd[i] = DW'($urandom);
        idx = 0;
        cyc = 0;
        while (idx < 48 && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = rnd[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_all_sent", idx, 48);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset during row 3 with a column held by the sink.
        for (int p = 0; p < 13; p++) send(DW'(200 + p));
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_y", out_y, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_col", out_column, 0);
        chk("async_rst_y", out_y, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) send_prime(DW'(100 + p));
        send(8'd108);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_y", out_y, 2);
        chk("post_rst_x", out_x, 0);
        chk("post_rst_col", out_column, 24'h64686C);
        @(posedge clk);
        #1;

        repeat (4) @(posedge clk);
        #1;
        chk("model_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised line buffer with valid/ready streaming on both sides. It accepts a raster pixel stream and emits, for every accepted pixel once enough rows are primed, a vertical column of KERNEL_H pixels: the current pixel plus the pixels at the same column in the previous KERNEL_H-1 rows. It also emits column/row coordinates, a horizontal border flag and an end-of-frame marker. It sits between the pixel source and the kernel/gradient stages and replaces the single-line FIFO approach with a frame-aware, backpressure-safe window generator.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line (>= KERNEL_W)
- IMG_HEIGHT, 480, lines per frame (>= KERNEL_H)
- KERNEL_H, 3, window height; KERNEL_H-1 line memories, KERNEL_H >= 2
- KERNEL_W, 3, window width; used only for border_flag, KERNEL_W >= 1
- XW = $clog2(IMG_WIDTH), YW = $clog2(IMG_HEIGHT) (localparams)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  pixel
- in_valid  in  1  source has pixel
- in_ready  out  1  block accepts pixel this cycle
- out_column  out  KERNEL_H*DATA_WIDTH  slice i (bits DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i) = pixel of row out_y-i; i=0 is the current row
- out_x  out  XW  column of the current (bottom) pixel
- out_y  out  YW  row of the current pixel
- border_flag  out  1  high when out_x < KERNEL_W-1 (horizontal window incomplete)
- frame_last  out  1  high with the output for pixel (IMG_WIDTH-1, IMG_HEIGHT-1)
- out_valid  out  1  output register holds a valid column
- out_ready  in  1  sink accepts column

## Operation
- Accept: acc = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- Counters x, y: on acc, x increments. At x == IMG_WIDTH-1, x -> 0 and y increments. At y == IMG_HEIGHT-1 with x == IMG_WIDTH-1, y -> 0. Counters change only on acc.
- Line memories L[0..KERNEL_H-2], each IMG_WIDTH x DATA_WIDTH, all addressed by x.
  - Read is asynchronous, of the pre-write contents.
  - On acc: L[0][x] <= in_data and L[k][x] <= old L[k-1][x] (shift-down).
- Output register loads on acc:
  - out_column slice 0 = in_data; slice i = old L[i-1][x].
  - out_x = x, out_y = y, border_flag = (x < KERNEL_W-1), frame_last = (x, y) is the last pixel.
- out_valid next state:
  - On acc: out_valid <= (y >= KERNEL_H-1).
  - Else if out_ready: out_valid <= 0.
  - Else: hold.
- Priming: pixels of rows 0..KERNEL_H-2 of every frame are written to memory but produce no output. Stale data from the previous frame therefore never appears in out_column.
- The memory is not reset and not cleared at frame wrap.
- Output fields are held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from acc to out_valid/out_column.
- Throughput: 1 pixel/cycle with out_ready held high; no bubbles inserted.
- Reset values: out_valid=0, out_column=0, out_x=0, out_y=0, border_flag=0, frame_last=0, in_ready=1, x=y=0.
- Reset mid-frame: next accepted pixel is (0,0) and priming restarts. No output until row KERNEL_H-1 is reached again.
- Simultaneous acc with out_ready=1 while out_valid=1: old column is consumed and the new column loaded in the same edge.
- Backpressure: in_ready falls in the same cycle out_ready is low with out_valid high. The source pixel is not consumed and the counters do not move.
- Wrap at frame end and at line end occurs on the same acc edge as the write.

## Test plan
Parameters for all scenarios: DATA_WIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=4, KERNEL_H=3, KERNEL_W=3. Pixel value = 4*y + x.
- Priming: stream 8 pixels (rows 0-1), out_ready=1 -> out_valid stays 0, in_ready stays 1.
- First window: pixel 8 at (0,2) -> next cycle out_valid=1, slices {0:8, 1:4, 2:0}, out_x=0, out_y=2, border_flag=1. Pixel 10 -> slices {10,6,2}, border_flag=0.
- Backpressure: out_ready=0 after pixel 9 output -> in_ready=0, outputs frozen for 5 cycles. Release -> pixel 10 accepted, no pixel lost or duplicated.
- Frame wrap: pixel 15 -> frame_last=1 with slices {15,11,7}. Next frame: rows 0-1 give no out_valid; (0,2) yields fresh-frame data only.
- Random in_valid/out_ready bubbles over 3 frames -> output sequence identical to the no-bubble run.
- Reset asserted during row 3 -> outputs at reset values immediately. After release, 8 pixels give no output; the 9th gives out_y=2, out_x=0.
